if_parcel_queue: RTL
====================

IF_PARCEL_QUEUE -- requirements
Module: if_parcel_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter PARCEL_SIZE, default 32, parcel width; if_parcel_valid width is PARCEL_SIZE/16.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of 2, minimum 2.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port if_nxt_pc  in  XLEN  next fetch PC from core.
REQ-007 SHALL have port if_stall_nxt_pc  out  1  core holds if_nxt_pc while high.
REQ-008 SHALL have ports if_stall, if_flush  in  1 each; core not consuming / discard all fetches.
REQ-009 SHALL have ports if_parcel (PARCEL_SIZE), if_parcel_pc (XLEN), if_parcel_valid (PARCEL_SIZE/16), if_parcel_misaligned (1), if_parcel_page_fault (1), all out, head entry to core.
REQ-010 SHALL have ports imem_req out 1, imem_adr out XLEN, imem_ack in 1; request accepted when both imem_req and imem_ack are high.
REQ-011 SHALL have ports imem_rvalid in 1, imem_q in PARCEL_SIZE, imem_err in 1; in-order responses, one per accepted request.

Function
REQ-012 SHALL keep a circular queue of DEPTH entries {pc, parcel, filled, misaligned, err} with head/tail pointers and occupancy counter of width clog2(DEPTH)+1.
REQ-013 SHALL allocate an entry at tail on each accepted request, recording pc = if_nxt_pc, filled = 0.
REQ-014 SHALL drive imem_req = !rst & !if_flush & (occupancy < DEPTH) & (if_nxt_pc[1:0] == 0), imem_adr = if_nxt_pc.
REQ-015 SHALL, when if_nxt_pc[1:0] != 0, occupancy < DEPTH and !if_flush, allocate an entry with filled = 1, misaligned = 1 and issue no memory request.
REQ-016 SHALL drive if_stall_nxt_pc = !(request accepted | misaligned entry allocated), combinationally.
REQ-017 SHALL fill the oldest unfilled entry with imem_q and imem_err on imem_rvalid, registered at the next rising edge.
REQ-018 SHALL expose the head entry registered: if_parcel_valid = all ones when occupancy > 0 and head filled, else all zeros; earliest valid is cycle A+2 for a response in cycle A+1 to a request accepted in cycle A.
REQ-019 SHALL drive if_parcel_page_fault = head.err and if_parcel_misaligned = head.misaligned, qualified by if_parcel_valid.
REQ-020 SHALL pop the head at the clock edge when if_parcel_valid is nonzero and if_stall is low.
REQ-021 SHALL, with simultaneous push and pop, leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-022 SHALL, on if_flush, empty the queue at the next edge (occupancy 0, head = tail) and load discard counter with the number of requests accepted but not yet responded to, excluding any response arriving in the flush cycle.
REQ-023 SHALL drop responses while discard counter > 0, decrementing it by one per imem_rvalid; a response in the flush cycle is dropped without touching the counter.
REQ-024 SHALL count queue occupancy plus discard counter against DEPTH, so outstanding memory requests never exceed DEPTH.
REQ-025 SHALL ignore imem_rvalid when no request is outstanding.
REQ-026 SHALL give if_flush priority over pop and fill in the same cycle.

Reset
REQ-027 SHALL on rst: occupancy 0, head = tail = 0, discard counter 0, all filled flags 0; if_parcel_valid 0, if_parcel 0, if_parcel_pc 0, flags 0.
REQ-028 SHALL force imem_req low and if_stall_nxt_pc high while rst is asserted; reset mid-operation abandons all outstanding requests.

Verification
REQ-029 SHALL cover single fetch: if_nxt_pc=0x200, imem_ack=1 in cycle 0, imem_rvalid with imem_q=0x00000013 in cycle 1 -> cycle 2 if_parcel_valid=2'b11, if_parcel=0x00000013, if_parcel_pc=0x200.
REQ-030 SHALL cover full queue: DEPTH=4, if_stall=1, four accepted requests with responses -> imem_req=0, if_stall_nxt_pc=1; releasing if_stall pops 0x200..0x20C in order.
REQ-031 SHALL cover flush with 2 outstanding: if_flush at cycle 5 -> next 2 imem_rvalid dropped, next fetch at 0x300 delivers if_parcel_pc=0x300.
REQ-032 SHALL cover misaligned PC: if_nxt_pc=0x202 -> no imem_req, next cycle if_parcel_valid=2'b11, if_parcel_misaligned=1.
REQ-033 SHALL cover bus error: response with imem_err=1 -> if_parcel_page_fault=1 with that entry's pc.
REQ-034 SHALL cover rst asserted with 3 entries queued -> all outputs 0 asynchronously; after release, first fetch behaves as in REQ-029.

Source files
------------

// File: rtl/if_parcel_queue.sv
// Instruction-fetch parcel queue: issues in-order memory requests for the core's
// next PC, collects the responses and presents the oldest entry to the decoder.
module if_parcel_queue #(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 32,
    parameter int DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [XLEN-1:0]           if_nxt_pc,
    output logic                      if_stall_nxt_pc,
    input  logic                      if_stall,
    input  logic                      if_flush,

    output logic [PARCEL_SIZE-1:0]    if_parcel,
    output logic [XLEN-1:0]           if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                      if_parcel_misaligned,
    output logic                      if_parcel_page_fault,

    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_adr,
    input  logic                      imem_ack,
    input  logic                      imem_rvalid,
    input  logic [PARCEL_SIZE-1:0]    imem_q,
    input  logic                      imem_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int VLD_W = PARCEL_SIZE / 16;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]        pc_q     [DEPTH];
    logic [PARCEL_SIZE-1:0] parcel_q [DEPTH];
    logic [DEPTH-1:0]       filled_q;
    logic [DEPTH-1:0]       mis_q;
    logic [DEPTH-1:0]       err_q;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] discard_q;

    logic             has_room;
    logic             aligned;
    logic             accept;
    logic             mis_alloc;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic             rsp_drop;
    logic             fill;

    logic [CNT_W-1:0] pend_cnt;
    logic             pend_found;
    logic [PTR_W-1:0] pend_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [CNT_W-1:0] outstanding;
    logic             flush_rsp;
    logic [CNT_W-1:0] discard_nxt;

    // Responses still owed to flushed entries occupy slots just like live entries,
    // so the number of requests in flight can never exceed DEPTH.
    assign has_room  = ({1'b0, occ_q} + {1'b0, discard_q}) < DEPTH_C;
    assign aligned   = (if_nxt_pc[1:0] == 2'b00);

    assign imem_req  = !rst && !if_flush && has_room && aligned;
    assign imem_adr  = if_nxt_pc;
    assign accept    = imem_req && imem_ack;
    assign mis_alloc = !rst && !if_flush && has_room && !aligned;
    assign push      = accept || mis_alloc;

    assign if_stall_nxt_pc = !push;

    assign head_valid = (occ_q != '0) && filled_q[head_q];
    assign pop        = head_valid && !if_stall && !if_flush;

    // Oldest occupied entry still waiting for memory, plus how many such entries exist.
    always_comb begin
        pend_cnt   = '0;
        pend_found = 1'b0;
        pend_idx   = head_q;
        scan_idx   = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < occ_q) && !filled_q[scan_idx]) begin
                pend_cnt = pend_cnt + CNT_W'(1);
                if (!pend_found) begin
                    pend_found = 1'b1;
                    pend_idx   = scan_idx;
                end
            end
        end
    end

    assign rsp_drop = (discard_q != '0);
    assign fill     = imem_rvalid && !if_flush && !rsp_drop && pend_found;

    // A response landing in the flush cycle is already accounted for, so it is
    // removed from the count of responses still to be discarded.
    assign outstanding = discard_q + pend_cnt;
    assign flush_rsp   = imem_rvalid && (outstanding != '0);
    assign discard_nxt = outstanding - CNT_W'(flush_rsp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            discard_q <= '0;
            filled_q  <= '0;
            mis_q     <= '0;
            err_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                parcel_q[i] <= '0;
            end
        end else if (if_flush) begin
            occ_q     <= '0;
            head_q    <= tail_q;
            discard_q <= discard_nxt;
        end else begin
            // Misaligned entries carry a zero parcel; only their flag is meaningful.
            if (push) begin
                pc_q[tail_q]     <= if_nxt_pc;
                parcel_q[tail_q] <= '0;
                filled_q[tail_q] <= mis_alloc;
                mis_q[tail_q]    <= mis_alloc;
                err_q[tail_q]    <= 1'b0;
                tail_q           <= tail_q + PTR_W'(1);
            end
            if (fill) begin
                parcel_q[pend_idx] <= imem_q;
                err_q[pend_idx]    <= imem_err;
                filled_q[pend_idx] <= 1'b1;
            end
            if (imem_rvalid && rsp_drop) begin
                discard_q <= discard_q - CNT_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign if_parcel_valid      = {VLD_W{head_valid}};
    assign if_parcel            = parcel_q[head_q];
    assign if_parcel_pc         = pc_q[head_q];
    assign if_parcel_misaligned = head_valid && mis_q[head_q];
    assign if_parcel_page_fault = head_valid && err_q[head_q];

endmodule
